// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-serial instruction memory loader.
// Opcodes, FSM states and the bytes-per-word calculation.
package imem_loader_pkg;

    localparam logic [7:0] CMD_SETADDR = 8'hA5;
    localparam logic [7:0] CMD_WRITE   = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        COUNT,
        DATA,
        WRITE
    } state_t;

    function automatic int calc_bpw(int ib, int iw, int dw);
        return (ib * iw + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte handshake plus instruction memory write port.
// master = host side, slave = loader side.
interface imem_loader_if #(
    parameter int d_width       = 8,
    parameter int i_adr_width   = 10,
    parameter int i_width       = 20,
    parameter int i_buffer_size = 2
);

    logic [d_width-1:0]               host_data;
    logic                             host_valid;
    logic                             host_ready;
    logic [i_adr_width-1:0]           imem_write_adr;
    logic                             imem_write;
    logic [i_buffer_size*i_width-1:0] imem_in;

    modport master (
        output host_data,
        output host_valid,
        input  host_ready,
        input  imem_write_adr,
        input  imem_write,
        input  imem_in
    );

    modport slave (
        input  host_data,
        input  host_valid,
        output host_ready,
        output imem_write_adr,
        output imem_write,
        output imem_in
    );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte shift register; flags the handshake of a word's last byte.
// word presents the complete word in that same cycle so the caller can register it.
module imem_loader_byte_assembler #(
    parameter int d_w = 8,
    parameter int bpw = 5,
    parameter int w_w = 40
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           en,
    input  logic [d_w-1:0] din,
    output logic [w_w-1:0] word,
    output logic           word_ready
);

    localparam int AW = bpw * d_w;
    localparam int IW = (bpw > 1) ? $clog2(bpw) : 1;

    logic [AW-1:0] sr;
    logic [AW-1:0] sr_n;
    logic [IW-1:0] idx;

    // New bytes enter at the top, so the first byte ends up in bits [d_w-1:0]
    generate
        if (bpw > 1) begin : g_shift
            assign sr_n = {din, sr[AW-1:d_w]};
        end else begin : g_single
            assign sr_n = din;
        end
    endgenerate

    assign word_ready = en && (idx == IW'(bpw - 1));
    assign word       = w_w'(sr_n);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sr  <= '0;
            idx <= '0;
        end else if (en) begin
            sr  <= sr_n;
            idx <= word_ready ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed command loader: SET_ADDR / WRITE commands into the instruction buffer.
// loader_busy holds the core in reset while any command is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int d_width       = 8,
    parameter int i_adr_width   = 10,
    parameter int i_width       = 20,
    parameter int i_buffer_size = 2
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          loader_busy,
    output logic          load_done,
    output logic          cmd_err
);

    localparam int BPW = calc_bpw(i_buffer_size, i_width, d_width);
    localparam int W_W = i_buffer_size * i_width;
    localparam int CW  = d_width + 1;

    state_t state;
    state_t state_n;

    logic                   fire;
    logic [d_width-1:0]     adr_lo;
    logic [i_adr_width-1:0] addr;
    logic [CW-1:0]          cnt;
    logic [W_W-1:0]         word;
    logic                   word_ready;
    logic                   is_setaddr;
    logic                   is_write;

    assign fire       = bus.host_valid && bus.host_ready;
    assign is_setaddr = bus.host_data == d_width'(CMD_SETADDR);
    assign is_write   = bus.host_data == d_width'(CMD_WRITE);

    imem_loader_byte_assembler #(
        .d_w (d_width),
        .bpw (BPW),
        .w_w (W_W)
    ) byte_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != DATA),
        .en         (fire && (state == DATA)),
        .din        (bus.host_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (fire && is_setaddr) state_n = ADDR_LO;
                else if (fire && is_write) state_n = COUNT;
            end
            ADDR_LO: if (fire) state_n = ADDR_HI;
            ADDR_HI: if (fire) state_n = IDLE;
            COUNT:   if (fire) state_n = DATA;
            DATA:    if (word_ready) state_n = WRITE;
            WRITE:   state_n = (cnt == CW'(1)) ? IDLE : DATA;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            bus.host_ready     <= 1'b0;
            bus.imem_write     <= 1'b0;
            bus.imem_write_adr <= '0;
            bus.imem_in        <= '0;
            loader_busy        <= 1'b0;
            load_done          <= 1'b0;
            cmd_err            <= 1'b0;
            adr_lo             <= '0;
            addr               <= '0;
            cnt                <= '0;
        end else begin
            state          <= state_n;
            bus.host_ready <= state_n != WRITE;
            loader_busy    <= state_n != IDLE;
            bus.imem_write <= state_n == WRITE;
            // cnt is still the pre-decrement value on entry to WRITE
            load_done      <= (state_n == WRITE) && (cnt == CW'(1));
            if (state == IDLE && fire && !is_setaddr && !is_write)
                cmd_err <= 1'b1;
            if (state == ADDR_LO && fire)
                adr_lo <= bus.host_data;
            if (state == ADDR_HI && fire)
                addr <= i_adr_width'({bus.host_data, adr_lo});
            if (state == COUNT && fire)
                cnt <= {bus.host_data == '0, bus.host_data};
            if (word_ready) begin
                bus.imem_in        <= word;
                bus.imem_write_adr <= addr;
            end
            if (state == WRITE) begin
                addr <= addr + i_adr_width'(i_buffer_size);
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, wrap, errors, gaps, reset, 256-word load.
// Writes are captured at the falling edge and compared against hand-computed values.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;
    logic loader_busy;
    logic load_done;
    logic cmd_err;

    always #5 clk = ~clk;

    imem_loader_if #(
        .d_width(8), .i_adr_width(10), .i_width(20), .i_buffer_size(2)
    ) bus ();

    imem_loader #(
        .d_width(8), .i_adr_width(10), .i_width(20), .i_buffer_size(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .loader_busy (loader_busy),
        .load_done   (load_done),
        .cmd_err     (cmd_err)
    );

    logic [9:0]  wadr_q[$];
    logic [39:0] wdat_q[$];
    int done_n  = 0;
    int busy_n  = 0;
    int rdylo_n = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_write) begin
                wadr_q.push_back(bus.imem_write_adr);
                wdat_q.push_back(bus.imem_in);
            end
            if (load_done) done_n++;
            if (loader_busy) busy_n++;
            if (!bus.host_ready) rdylo_n++;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        bus.host_data  = b;
        bus.host_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.host_ready;
            @(posedge clk);
            #1;
        end
        bus.host_valid = 1'b0;
        if (!acc) chk("hs_timeout", {63'b0, acc}, 64'd1);
        idle(gap);
    endtask

    task automatic send_word(input logic [39:0] w, input int maxgap);
        for (int k = 0; k < 5; k++)
            send(w[8*k +: 8], $urandom_range(maxgap, 0));
    endtask

    task automatic do_reset();
        bus.host_valid = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    function automatic logic [39:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA0, b + 8'd1, 8'h3C, ~b, b};
    endfunction

    int base;
    int d0;
    int b0;
    int r0;

    initial begin
        reset          = 1'b1;
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        idle(3);
        @(negedge clk);
        chk("rst_ready", bus.host_ready, 0);
        chk("rst_adr", bus.imem_write_adr, 0);
        chk("rst_wr", bus.imem_write, 0);
        chk("rst_in", bus.imem_in, 0);
        chk("rst_busy", loader_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", cmd_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        @(negedge clk);
        chk("ready_after_rst", bus.host_ready, 1);
        @(posedge clk);
        #1;

        // basic single-word load
        base = wadr_q.size(); d0 = done_n; b0 = busy_n;
        send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
        send(8'h5A, 0); send(8'h01, 0);
        send_word(40'h5544332211, 0);
        idle(5);
        @(negedge clk);
        chk("s1_nwr", wadr_q.size() - base, 1);
        chk("s1_adr", wadr_q[base], 10'h010);
        chk("s1_dat", wdat_q[base], 40'h5544332211);
        chk("s1_done", done_n - d0, 1);
        chk("s1_busy_seen", busy_n > b0, 1);
        chk("s1_busy_end", loader_busy, 0);
        chk("s1_err", cmd_err, 0);
        chk("s1_hold", bus.imem_in, 40'h5544332211);
        @(posedge clk);
        #1;

        // address wrap and stall cycles
        base = wadr_q.size(); d0 = done_n; r0 = rdylo_n;
        send(8'hA5, 0); send(8'hFE, 0); send(8'h03, 0);
        send(8'h5A, 0); send(8'h02, 0);
        send_word(40'h0102030405, 0);
        send_word(40'hA1B2C3D4E5, 0);
        idle(5);
        @(negedge clk);
        chk("wrap_nwr", wadr_q.size() - base, 2);
        chk("wrap_adr0", wadr_q[base], 10'h3FE);
        chk("wrap_adr1", wadr_q[base+1], 10'h000);
        chk("wrap_dat0", wdat_q[base], 40'h0102030405);
        chk("wrap_dat1", wdat_q[base+1], 40'hA1B2C3D4E5);
        chk("wrap_stall", rdylo_n - r0, 2);
        chk("wrap_done", done_n - d0, 1);
        @(posedge clk);
        #1;

        // unknown command
        b0 = busy_n;
        send(8'h00, 0);
        idle(3);
        @(negedge clk);
        chk("err_set", cmd_err, 1);
        chk("err_nobusy", busy_n - b0, 0);
        @(posedge clk);
        #1;
        base = wadr_q.size();
        send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
        send(8'h5A, 0); send(8'h01, 0);
        send_word(40'hDEADBEEF01, 0);
        idle(5);
        @(negedge clk);
        chk("err_next_nwr", wadr_q.size() - base, 1);
        chk("err_next_adr", wadr_q[base], 10'h010);
        chk("err_next_dat", wdat_q[base], 40'hDEADBEEF01);
        chk("err_sticky", cmd_err, 1);
        @(posedge clk);
        #1;

        // valid gaps
        do_reset();
        @(negedge clk);
        chk("err_cleared", cmd_err, 0);
        @(posedge clk);
        #1;
        base = wadr_q.size(); d0 = done_n;
        send(8'hA5, $urandom_range(3, 0)); send(8'h10, $urandom_range(3, 0));
        send(8'h00, $urandom_range(3, 0)); send(8'h5A, $urandom_range(3, 0));
        send(8'h01, $urandom_range(3, 0));
        send_word(40'h5544332211, 3);
        idle(5);
        @(negedge clk);
        chk("gap_nwr", wadr_q.size() - base, 1);
        chk("gap_adr", wadr_q[base], 10'h010);
        chk("gap_dat", wdat_q[base], 40'h5544332211);
        chk("gap_done", done_n - d0, 1);
        chk("gap_busy_end", loader_busy, 0);
        @(posedge clk);
        #1;

        // reset in the middle of a word
        base = wadr_q.size();
        send(8'hA5, 0); send(8'h30, 0); send(8'h00, 0);
        send(8'h5A, 0); send(8'h01, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        do_reset();
        @(negedge clk);
        chk("rmid_nwr", wadr_q.size() - base, 0);
        chk("rmid_adr", bus.imem_write_adr, 0);
        chk("rmid_busy", loader_busy, 0);
        @(posedge clk);
        #1;
        send(8'hA5, 0); send(8'h20, 0); send(8'h00, 0);
        send(8'h5A, 0); send(8'h01, 0);
        send_word(40'h0BADC0FFEE, 0);
        idle(5);
        @(negedge clk);
        chk("rmid_next_nwr", wadr_q.size() - base, 1);
        chk("rmid_next_adr", wadr_q[base], 10'h020);
        chk("rmid_next_dat", wdat_q[base], 40'h0BADC0FFEE);
        @(posedge clk);
        #1;

        // count 0 means 256 words
        base = wadr_q.size(); d0 = done_n;
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h5A, 0); send(8'h00, 0);
        for (int i = 0; i < 256; i++) send_word(pat(i), 0);
        idle(5);
        @(negedge clk);
        chk("n256_nwr", wadr_q.size() - base, 256);
        if (wadr_q.size() - base == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("n256_adr%0d", i), wadr_q[base+i], 2 * i);
                chk($sformatf("n256_dat%0d", i), wdat_q[base+i], pat(i));
            end
        end
        chk("n256_done", done_n - d0, 1);
        chk("n256_busy_end", loader_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
